wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//   Write-back stage of the 5-stage MIPS pipeline, directly downstream of the memory-access stage.
//   - Consumes the 118-bit MEM->WB bus and retires one instruction per valid cycle.
//   - Drives the register-file write port.
//   - Owns the HI/LO registers and the CP0 registers STATUS, CAUSE, EPC and COUNT.
//   - Resolves syscall/eret into a redirect plus a pipeline cancel.
// PARAMETERS
//   EXC_ENTRY   32'h0000_0100  PC redirect target on syscall
//   COUNT_DIV   2              COUNT increments once every COUNT_DIV cycles (>=1)
// PORTS
//   clk            in   1    clock
//   reset          in   1    synchronous, active-high reset
//   WB_valid       in   1    bus register holds a live instruction this cycle
//   MEM_WB_bus_r   in   118  {rf_wen,rf_wdest[4:0],mem_result,lo_result,hi_write,lo_write,
//                            mfhi,mflo,mtc0,mfc0,cp0r_addr[7:0],syscall,eret,pc}
//   rf_wen         out  1    regfile write enable
//   rf_wdest       out  5    regfile write address
//   rf_wdata       out  32   regfile write data
//   WB_over        out  1    instruction retires this cycle
//   WB_wdest       out  5    pending dest for hazard detection; 0 when !WB_valid
//   exc_valid      out  1    redirect fetch this cycle
//   exc_pc         out  32   redirect target
//   cancel         out  1    flush IF/ID/EXE/MEM this cycle
//   WB_pc          out  32   PC of instruction in WB (display)
//   HI_data        out  32   HI register (display)
//   LO_data        out  32   LO register (display)
// BEHAVIOUR
// - Reset: HI=LO=0, STATUS=32'h0000_0002 (EXL=1), CAUSE=0, EPC=0, COUNT=0, divider=0.
// - All outputs are combinational from the bus and the state, so each is 0 with WB_valid=0,
//   except WB_pc, HI_data, LO_data, exc_pc, rf_wdest.
// - Latency and handshake:
//   - WB_over = WB_valid; single-cycle retire, WB always accepts.
//   - All state updates happen on the clk edge ending a WB_valid cycle; none when !WB_valid.
// - Register-file write port:
//   - rf_wen = bus.rf_wen & WB_valid.
//   - rf_wdata priority: mfhi ? HI : mflo ? LO : mfc0 ? cp0_rdata : mem_result.
// - HI/LO: hi_write -> HI<=mem_result; lo_write -> LO<=lo_result. Both may be set (mult).
// - cp0r_addr = {rd,sel}.
//   - Decode: STATUS={12,0}, CAUSE={13,0}, EPC={14,0}, COUNT={9,0}.
//   - Any other address reads 0 and ignores writes.
// - mtc0 writes mem_result to the addressed register:
//   - STATUS: only bits [15:8] (IM) and bit 1 (EXL) are writable; all other bits read 0.
//   - CAUSE: read-only from mtc0; the write is ignored.
//   - COUNT: the written value is loaded and the divider is cleared; this overrides the
//     increment in the same cycle.
// - COUNT: divider counts 0..COUNT_DIV-1 every cycle regardless of WB_valid.
//   - COUNT increments when the divider wraps; 32-bit wrap FFFF_FFFF->0.
// - syscall (WB_valid & syscall):
//   - If STATUS.EXL=0: EPC<=pc. If EXL=1: EPC is unchanged.
//   - EXL<=1; CAUSE[6:2]<=5'd8.
//   - exc_valid=1, exc_pc=EXC_ENTRY, cancel=1.
//   - rf_wen forced 0 (a syscall never writes the regfile).
// - eret (WB_valid & eret): EXL<=0; exc_valid=1; exc_pc=current EPC register; cancel=1.
// - Ordering: an mtc0 to EPC at cycle N is visible to an eret retiring at cycle N+1.
//   No intra-stage forwarding is needed.
// - syscall and eret are mutually exclusive by decode; if both are set, syscall wins.
// - Reset asserted mid-instruction: the reset values win and no update happens that cycle.
// TESTING
// - Reset, then idle 5 cycles, COUNT_DIV=2 -> COUNT=2; rf_wen=0; exc_valid=0; STATUS=0x2.
// - mult retire: hi_write=lo_write=1, mem_result=0x1, lo_result=0xFFFF_FFFE.
//   Then mfhi retires -> rf_wdata=0x1; then mflo retires -> rf_wdata=0xFFFF_FFFE.
// - mtc0 STATUS=0 (EXL=0), then syscall with pc=0x40 -> same cycle exc_valid=1,
//   exc_pc=0x100, cancel=1, rf_wen=0.
//   Next cycle: EPC=0x40, CAUSE[6:2]=8, EXL=1.
// - Second syscall at pc=0x100 with EXL=1 -> EPC stays 0x40.
// - mtc0 EPC=0x44, then eret on the next cycle -> exc_pc=0x44, cancel=1; then EXL=0.
// - mtc0 COUNT=0xFFFF_FFFF -> wraps to 0 after COUNT_DIV cycles.
//   WB_valid=0 with rf_wen set in the bus -> rf_wen=0, WB_wdest=0, no state change.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB bus plus the write-back stage's outputs.
// The memory stage (master) drives the bus, and wb_stage (slave) consumes it.
interface wb_stage_if;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic         exc_valid;
  logic [31:0]  exc_pc;
  logic         cancel;
  logic [31:0]  WB_pc;
  logic [31:0]  HI_data;
  logic [31:0]  LO_data;

  modport master (
    output WB_valid, MEM_WB_bus_r,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest,
           exc_valid, exc_pc, cancel, WB_pc, HI_data, LO_data
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest,
           exc_valid, exc_pc, cancel, WB_pc, HI_data, LO_data
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: regfile write port, HI/LO, CP0 (STATUS/CAUSE/EPC/COUNT),
// and syscall/eret redirect with pipeline cancel. Single-cycle retire.
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_0100,
  parameter int          COUNT_DIV = 2
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave wb
);

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
  } bus_t;

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] ADDR_COUNT  = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC    = {5'd14, 3'd0};
  localparam int         DIV_W       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  bus_t bus;
  assign bus = wb.MEM_WB_bus_r;

  logic [31:0]      hi, lo, epc, count;
  logic [7:0]       status_im;
  logic             status_exl;
  logic [4:0]       cause_exc;
  logic [DIV_W-1:0] div;
  logic             div_wrap;
  logic [31:0]      status, cause, cp0_rdata;
  logic             exc_take;

  assign status   = {16'b0, status_im, 6'b0, status_exl, 1'b0};
  assign cause    = {25'b0, cause_exc, 2'b0};
  assign div_wrap = (div == DIV_W'(COUNT_DIV - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cp0_rdata = '0;
    case (bus.cp0r_addr)
      ADDR_STATUS: cp0_rdata = status;
      ADDR_CAUSE:  cp0_rdata = cause;
      ADDR_EPC:    cp0_rdata = epc;
      ADDR_COUNT:  cp0_rdata = count;
      default:     cp0_rdata = '0;
    endcase
  end

  assign exc_take     = wb.WB_valid & (bus.syscall | bus.eret);
  assign wb.WB_over   = wb.WB_valid;
  assign wb.rf_wen    = bus.rf_wen & wb.WB_valid & ~bus.syscall;
  assign wb.rf_wdest  = bus.rf_wdest;
  assign wb.WB_wdest  = bus.rf_wdest & {5{wb.WB_valid}};
  assign wb.rf_wdata  = !wb.WB_valid ? 32'b0     :
                        bus.mfhi     ? hi        :
                        bus.mflo     ? lo        :
                        bus.mfc0     ? cp0_rdata : bus.mem_result;
  assign wb.exc_valid = exc_take;
  assign wb.cancel    = exc_take;
  assign wb.exc_pc    = bus.syscall ? EXC_ENTRY : epc;
  assign wb.WB_pc     = bus.pc;
  assign wb.HI_data   = hi;
  assign wb.LO_data   = lo;

  // NOTE: state uses non-blocking assignments; a later assignment in this block
  // deliberately overrides an earlier one (COUNT load over increment, syscall
  // EXL over an mtc0 STATUS write in the same cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= '0;
      lo         <= '0;
      epc        <= '0;
      count      <= '0;
      div        <= '0;
      status_im  <= '0;
      status_exl <= 1'b1;
      cause_exc  <= '0;
    end else begin
      div <= div_wrap ? '0 : div + DIV_W'(1);
      if (div_wrap) count <= count + 32'd1;

      if (wb.WB_valid) begin
        if (bus.hi_write) hi <= bus.mem_result;
        if (bus.lo_write) lo <= bus.lo_result;

        if (bus.mtc0) begin
          case (bus.cp0r_addr)
            ADDR_STATUS: begin
              status_im  <= bus.mem_result[15:8];
              status_exl <= bus.mem_result[1];
            end
            ADDR_EPC:   epc <= bus.mem_result;
            ADDR_COUNT: begin
              count <= bus.mem_result;
              div   <= '0;
            end
            default: ;
          endcase
        end

        if (bus.syscall) begin
          if (!status_exl) epc <= bus.pc;
          status_exl <= 1'b1;
          cause_exc  <= 5'd8;
        end else if (bus.eret) begin
          status_exl <= 1'b0;
        end
      end
    end
  end

endmodule
